// File: rtl/quad_enc_counter.sv
// rtl/quad_enc_counter.sv - x4 quadrature decoder with sync/deglitch, snapshot and index latch
// Optional index homing (home_arm/homed) is built when ENC_INDEX_HOME_EN is defined.
module quad_enc_counter #(
    parameter int POS_WIDTH  = 32,
    parameter int FILTER_LEN = 4,
    parameter int DIR_INV    = 0
) (
    input  logic                 clk,
    input  logic                 sclr,
    input  logic                 A,
    input  logic                 B,
    input  logic                 Z,
    input  logic                 load,
    input  logic [POS_WIDTH-1:0] load_val,
    input  logic                 snapshot,
    input  logic                 err_clr,
`ifdef ENC_INDEX_HOME_EN
    input  logic                 home_arm,
    output logic                 homed,
`endif
    output logic [POS_WIDTH-1:0] pos,
    output logic [POS_WIDTH-1:0] snap,
    output logic [POS_WIDTH-1:0] index_pos,
    output logic                 index_flag,
    output logic                 changed,
    output logic                 err
);

    localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

    // bit 0 = A, bit 1 = B, bit 2 = Z
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_filt;
    logic [7:0] r_fcnt [3];

    logic [1:0]           r_prev_ab;
    logic                 r_prev_z;
    logic [POS_WIDTH-1:0] r_pos;
    logic [POS_WIDTH-1:0] r_snap;
    logic [POS_WIDTH-1:0] r_index_pos;
    logic                 r_index_flag;
    logic                 r_changed;
    logic                 r_err;
`ifdef ENC_INDEX_HOME_EN
    logic                 r_armed;
    logic                 r_homed;
    logic                 w_home;
`endif

    logic [1:0]           w_ab;
    logic                 w_fwd;
    logic                 w_rev;
    logic                 w_illegal;
    logic                 w_up;
    logic                 w_zrise;
    logic [POS_WIDTH-1:0] w_next_pos;

    // A sample must disagree with the filtered value for FILTER_LEN consecutive clocks to pass.
    always_ff @(posedge clk) begin
        if (sclr) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
            for (int i = 0; i < 3; i++) r_fcnt[i] <= '0;
        end else begin
            r_sync1 <= {Z, B, A};
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FILT_LAST) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 8'd1;
                end
            end
        end
    end

    assign w_ab    = {r_filt[0], r_filt[1]};
    assign w_zrise = r_filt[2] & ~r_prev_z;

    always_comb begin
        w_fwd     = 1'b0;
        w_rev     = 1'b0;
        w_illegal = 1'b0;
        case ({r_prev_ab, w_ab})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_fwd     = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_rev     = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_illegal = 1'b1;
            default: ;
        endcase
    end

    assign w_up       = (DIR_INV != 0) ? w_rev : w_fwd;
    assign w_next_pos = w_up ? (r_pos + POS_WIDTH'(1)) : (r_pos - POS_WIDTH'(1));

`ifdef ENC_INDEX_HOME_EN
    assign w_home = w_zrise & r_armed;
`endif

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_prev_ab    <= '0;
            r_prev_z     <= 1'b0;
            r_pos        <= '0;
            r_snap       <= '0;
            r_index_pos  <= '0;
            r_index_flag <= 1'b0;
            r_changed    <= 1'b0;
            r_err        <= 1'b0;
`ifdef ENC_INDEX_HOME_EN
            r_armed      <= 1'b0;
            r_homed      <= 1'b0;
`endif
        end else begin
            r_prev_ab <= w_ab;
            r_prev_z  <= r_filt[2];
            r_changed <= 1'b0;

            if (load) begin
                r_pos     <= load_val;
                r_changed <= 1'b1;
            end
`ifdef ENC_INDEX_HOME_EN
            else if (w_home) begin
                r_pos     <= '0;
                r_changed <= 1'b1;
                r_homed   <= 1'b1;
                r_armed   <= 1'b0;
            end
`endif
            else if (w_fwd || w_rev) begin
                r_pos     <= w_next_pos;
                r_changed <= 1'b1;
            end

`ifdef ENC_INDEX_HOME_EN
            // A fresh arm request overrides a coincident homing event's disarm.
            if (home_arm) begin
                r_armed <= 1'b1;
                r_homed <= 1'b0;
            end
`endif

            if (snapshot) r_snap <= r_pos;

            if (w_zrise) begin
                r_index_pos  <= r_pos;
                r_index_flag <= 1'b1;
            end else if (snapshot) begin
                r_index_flag <= 1'b0;
            end

            if (w_illegal)    r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

    assign pos        = r_pos;
    assign snap       = r_snap;
    assign index_pos  = r_index_pos;
    assign index_flag = r_index_flag;
    assign changed    = r_changed;
    assign err        = r_err;
`ifdef ENC_INDEX_HOME_EN
    assign homed      = r_homed;
`endif

endmodule

// File: tb/tb_quad_enc_counter.sv
// tb/tb_quad_enc_counter.sv - scoreboard bench for quad_enc_counter with a phase/arithmetic reference model
module tb_quad_enc_counter;

    localparam int PW  = 32;
    localparam int FL  = 4;
    localparam int DI  = 0;
    localparam int LAT = 2 + FL + 1;

    logic          clk = 1'b0;
    logic          sclr, A, B, Z, load, snapshot, err_clr;
    logic [PW-1:0] load_val;
    logic [PW-1:0] pos, snap, index_pos;
    logic          index_flag, changed, err;
`ifdef ENC_INDEX_HOME_EN
    logic          home_arm, homed;
`endif

    quad_enc_counter #(.POS_WIDTH(PW), .FILTER_LEN(FL), .DIR_INV(DI)) dut (
        .clk(clk), .sclr(sclr), .A(A), .B(B), .Z(Z),
        .load(load), .load_val(load_val), .snapshot(snapshot), .err_clr(err_clr),
`ifdef ENC_INDEX_HOME_EN
        .home_arm(home_arm), .homed(homed),
`endif
        .pos(pos), .snap(snap), .index_pos(index_pos),
        .index_flag(index_flag), .changed(changed), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PW-1:0] p;
        int            t_edge;
    } exp_t;

    exp_t          q[$];
    exp_t          mon_e;
    int            n_tests = 0;
    int            n_fail  = 0;

    int            m_idx;
    logic [PW-1:0] m_pos;
    logic [1:0]    gray [4];

    task automatic check(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Every changed pulse must match the oldest outstanding expected position.
    always @(negedge clk) begin
        if (!sclr && changed === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_changed actual_pos=%h expected=none", pos);
            end else begin
                mon_e = q.pop_front();
                check("sb_pos", pos, mon_e.p);
                if (mon_e.t_edge >= 0) check("first_latency", PW'(cyc - mon_e.t_edge), PW'(LAT));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step(input int dir, input int gap, input bit chk_lat);
        m_idx = (m_idx + dir) & 3;
        m_pos = m_pos + PW'((DI != 0) ? -dir : dir);
        q.push_back('{m_pos, chk_lat ? cyc : -1});
        {A, B} = gray[m_idx];
        tick(gap);
    endtask

    task automatic do_load(input logic [PW-1:0] v);
        load_val = v;
        load     = 1'b1;
        m_pos    = v;
        q.push_back('{m_pos, -1});
        tick(1);
        load = 1'b0;
    endtask

    task automatic pulse_snapshot();
        snapshot = 1'b1;
        tick(1);
        snapshot = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) tick(1);
        tick(3);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual_pending=%0d expected=0", q.size());
            q.delete();
        end
    endtask

    initial begin
        gray     = '{2'b00, 2'b01, 2'b11, 2'b10};
        sclr     = 1'b1;
        A        = 1'b0;
        B        = 1'b0;
        Z        = 1'b0;
        load     = 1'b0;
        load_val = '0;
        snapshot = 1'b0;
        err_clr  = 1'b0;
`ifdef ENC_INDEX_HOME_EN
        home_arm = 1'b0;
`endif
        m_idx    = 0;
        m_pos    = '0;
        tick(3);
        check("rst_pos", pos, '0);
        check("rst_changed", PW'(changed), '0);
        check("rst_err", PW'(err), '0);
        sclr = 1'b0;
        tick(2);

        for (int i = 0; i < 10; i++) step(1, 20, i == 0);
        drain();
        check("fwd10_pos", pos, PW'(10));
        for (int i = 0; i < 3; i++) step(-1, 20, 1'b0);
        drain();
        check("rev3_pos", pos, PW'(7));

        A = ~A;
        tick(2);
        A = ~A;
        tick(20);
        check("glitch_pos", pos, m_pos);
        check("glitch_err", PW'(err), '0);

        step(1, 20, 1'b0);
        drain();
        m_idx  = (m_idx + 2) & 3;
        {A, B} = gray[m_idx];
        tick(20);
        check("illegal_err", PW'(err), PW'(1));
        check("illegal_pos", pos, m_pos);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("errclr_err", PW'(err), '0);

        m_idx  = (m_idx + 2) & 3;
        {A, B} = gray[m_idx];
        tick(LAT - 1);
        check("err_before_illegal", PW'(err), '0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("errclr_coincident_err", PW'(err), PW'(1));
        tick(10);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("pos_after_illegal", pos, m_pos);

        do_load(32'h7FFF_FFFF);
        tick(3);
        step(1, 20, 1'b0);
        drain();
        check("wrap_up_pos", pos, 32'h8000_0000);
        do_load('0);
        tick(3);
        step(-1, 20, 1'b0);
        drain();
        check("wrap_down_pos", pos, 32'hFFFF_FFFF);

        do_load(PW'(5));
        tick(3);
        drain();
`ifdef ENC_INDEX_HOME_EN
        home_arm = 1'b1;
        tick(1);
        home_arm = 1'b0;
        check("home_cleared", PW'(homed), '0);
`endif
        Z = 1'b1;
`ifdef ENC_INDEX_HOME_EN
        m_pos = '0;
        q.push_back('{m_pos, -1});
`endif
        tick(LAT - 1);
        pulse_snapshot();
        tick(9);
        Z = 1'b0;
        tick(20);
        drain();
        check("index_pos", index_pos, PW'(5));
        check("index_snap", snap, PW'(5));
        check("index_flag_set", PW'(index_flag), PW'(1));
        check("index_live_pos", pos, m_pos);
`ifdef ENC_INDEX_HOME_EN
        check("homed_set", PW'(homed), PW'(1));
`endif
        pulse_snapshot();
        check("index_flag_clr", PW'(index_flag), '0);
        check("snap_after_index", snap, m_pos);

        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                step(($urandom_range(0, 1) != 0) ? 1 : -1, int'($urandom_range(7, 14)), 1'b0);
            end else if (r == 7) begin
                do_load(PW'($urandom));
            end else begin
                pulse_snapshot();
                check("rand_snap", snap, m_pos);
            end
        end
        drain();
        check("rand_pos", pos, m_pos);
        check("rand_err", PW'(err), '0);

        A    = 1'b0;
        B    = 1'b0;
        sclr = 1'b1;
        tick(1);
        sclr  = 1'b0;
        m_idx = 0;
        m_pos = '0;
        check("sclr_pos", pos, '0);
        check("sclr_snap", snap, '0);
        check("sclr_index_pos", index_pos, '0);
        check("sclr_index_flag", PW'(index_flag), '0);
        check("sclr_changed", PW'(changed), '0);
        check("sclr_err", PW'(err), '0);
        tick(15);
        step(1, 20, 1'b1);
        drain();
        check("post_sclr_pos", pos, PW'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
